// File: rtl/memory_register_read_stage_pkg.sv
// Shared types and helpers for the memory register-read stage: per-lane stage
// register layout and the selective recovery flush test.
package memory_register_read_stage_pkg;

    localparam int unsigned AL_PTR_W_DEF  = 6;
    localparam int unsigned IQ_PTR_W_DEF  = 4;
    localparam int unsigned PREG_W_DEF    = 7;
    localparam int unsigned PAYLOAD_W_DEF = 64;

    typedef struct packed {
        logic                                valid;
        logic                                replay;
        logic [IQ_PTR_W_DEF-1:0]             iq_ptr;
        logic [AL_PTR_W_DEF-1:0]             al_ptr;
        logic [1:0][PREG_W_DEF-1:0]          src;
        logic [PAYLOAD_W_DEF-1:0]            payload;
    } stage_reg_t;

    // Range [head, tail) is circular; head == tail without flush_all is empty.
    function automatic logic selective_flush_detector(
        input logic                    to_recovery,
        input logic [AL_PTR_W_DEF-1:0] head,
        input logic [AL_PTR_W_DEF-1:0] tail,
        input logic                    flush_all,
        input logic [AL_PTR_W_DEF-1:0] ptr
    );
        logic in_range;
        if (head <= tail) begin
            in_range = (ptr >= head) && (ptr < tail);
        end else begin
            in_range = (ptr >= head) || (ptr < tail);
        end
        return to_recovery && (flush_all || in_range);
    endfunction

endpackage

// File: rtl/operand_hold_buffer.sv
// Per-lane operand capture: freezes register-file data on the first stall cycle so the
// op held in the output register keeps its operands while the read port moves on.
module operand_hold_buffer #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic [W-1:0] rf_data,
    output logic [W-1:0] operand
);

    logic         stalled_q;
    logic [W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalled_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            stalled_q <= stall;
            if (stall && !stalled_q) begin
                hold_q <= rf_data;
            end
        end
    end

    assign operand = stalled_q ? hold_q : rf_data;

endmodule

// File: rtl/memory_register_read_stage.sv
// Two-register pipeline stage between memory issue and memory execute: A drives the
// register-file read addresses, B presents the op with its operands one cycle later.
module memory_register_read_stage
    import memory_register_read_stage_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned AL_PTR_W  = AL_PTR_W_DEF,
    parameter int unsigned IQ_PTR_W  = IQ_PTR_W_DEF,
    parameter int unsigned PREG_W    = PREG_W_DEF,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic                          in_replay,
    input  logic [WIDTH*IQ_PTR_W-1:0]     in_iq_ptr,
    input  logic [WIDTH*AL_PTR_W-1:0]     in_al_ptr,
    input  logic [WIDTH*2*PREG_W-1:0]     in_src,
    input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
    input  logic                          to_recovery,
    input  logic                          flush_all,
    input  logic [AL_PTR_W-1:0]           flush_head,
    input  logic [AL_PTR_W-1:0]           flush_tail,
    output logic [WIDTH*2*PREG_W-1:0]     rf_addr,
    input  logic [WIDTH*2*DATA_W-1:0]     rf_data,
    output logic [WIDTH-1:0]              out_valid,
    output logic [WIDTH-1:0]              out_replay,
    output logic [WIDTH*IQ_PTR_W-1:0]     out_iq_ptr,
    output logic [WIDTH*AL_PTR_W-1:0]     out_al_ptr,
    output logic [WIDTH*PAYLOAD_W-1:0]    out_payload,
    output logic [WIDTH*2*DATA_W-1:0]     out_operand
);

    stage_reg_t [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic       [WIDTH-1:0] in_flushed, a_flushed, b_flushed;

    always_comb begin
        for (int l = 0; l < int'(WIDTH); l++) begin
            in_flushed[l] = selective_flush_detector(to_recovery, flush_head, flush_tail,
                flush_all, in_al_ptr[l*AL_PTR_W +: AL_PTR_W]);
            a_flushed[l]  = selective_flush_detector(to_recovery, flush_head, flush_tail,
                flush_all, a_q[l].al_ptr);
            b_flushed[l]  = selective_flush_detector(to_recovery, flush_head, flush_tail,
                flush_all, b_q[l].al_ptr);
        end
    end

    // Stall holds every field; only the valid bits can still be knocked down by a flush.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        for (int l = 0; l < int'(WIDTH); l++) begin
            if (stall) begin
                a_d[l].valid = a_q[l].valid && !a_flushed[l];
                b_d[l].valid = b_q[l].valid && !b_flushed[l];
            end else begin
                a_d[l].valid   = in_valid[l] && !clear && !in_flushed[l];
                a_d[l].replay  = in_replay;
                a_d[l].iq_ptr  = in_iq_ptr[l*IQ_PTR_W +: IQ_PTR_W];
                a_d[l].al_ptr  = in_al_ptr[l*AL_PTR_W +: AL_PTR_W];
                a_d[l].src[0]  = in_src[(2*l)*PREG_W +: PREG_W];
                a_d[l].src[1]  = in_src[(2*l+1)*PREG_W +: PREG_W];
                a_d[l].payload = in_payload[l*PAYLOAD_W +: PAYLOAD_W];
                b_d[l]         = a_q[l];
                b_d[l].valid   = a_q[l].valid && !clear && !a_flushed[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        for (int l = 0; l < int'(WIDTH); l++) begin
            rf_addr[(2*l)*PREG_W +: PREG_W]     = a_q[l].src[0];
            rf_addr[(2*l+1)*PREG_W +: PREG_W]   = a_q[l].src[1];
            out_valid[l]                        = b_q[l].valid && !b_flushed[l];
            out_replay[l]                       = b_q[l].replay;
            out_iq_ptr[l*IQ_PTR_W +: IQ_PTR_W]  = b_q[l].iq_ptr;
            out_al_ptr[l*AL_PTR_W +: AL_PTR_W]  = b_q[l].al_ptr;
            out_payload[l*PAYLOAD_W +: PAYLOAD_W] = b_q[l].payload;
        end
    end

    for (genvar l = 0; l < int'(WIDTH); l++) begin : g_lane
        operand_hold_buffer #(
            .W (2*DATA_W)
        ) u_hold (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall),
            .rf_data (rf_data[l*2*DATA_W +: 2*DATA_W]),
            .operand (out_operand[l*2*DATA_W +: 2*DATA_W])
        );
    end

endmodule

// File: tb/tb_memory_register_read_stage.sv
// Directed plan scenarios plus randomized traffic, checked against a behavioural model
// of the two-deep op pipeline and a constant-content register file.
module tb_memory_register_read_stage;

    localparam int W = 2, AL = 6, IQ = 4, PR = 7, DW = 32, PL = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall, clear, in_replay, to_recovery, flush_all;
    logic [W-1:0]      in_valid;
    logic [W*IQ-1:0]   in_iq_ptr;
    logic [W*AL-1:0]   in_al_ptr;
    logic [W*2*PR-1:0] in_src;
    logic [W*PL-1:0]   in_payload;
    logic [AL-1:0]     flush_head, flush_tail;
    logic [W*2*PR-1:0] rf_addr;
    logic [W*2*DW-1:0] rf_data = '0;
    logic [W-1:0]      out_valid, out_replay;
    logic [W*IQ-1:0]   out_iq_ptr;
    logic [W*AL-1:0]   out_al_ptr;
    logic [W*PL-1:0]   out_payload;
    logic [W*2*DW-1:0] out_operand;

    memory_register_read_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear), .in_valid(in_valid),
        .in_replay(in_replay), .in_iq_ptr(in_iq_ptr), .in_al_ptr(in_al_ptr), .in_src(in_src),
        .in_payload(in_payload), .to_recovery(to_recovery), .flush_all(flush_all),
        .flush_head(flush_head), .flush_tail(flush_tail), .rf_addr(rf_addr),
        .rf_data(rf_data), .out_valid(out_valid), .out_replay(out_replay),
        .out_iq_ptr(out_iq_ptr), .out_al_ptr(out_al_ptr), .out_payload(out_payload),
        .out_operand(out_operand)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          replay;
        bit [IQ-1:0] iq;
        bit [AL-1:0] al;
        bit [PR-1:0] s0, s1;
        bit [PL-1:0] pl;
    } op_t;

    op_t     ma[W], mb[W];
    bit [DW-1:0] mem[128];
    int      n_checks = 0, n_fail = 0, n_exp = 0, n_got = 0;

    // Register file with one-cycle read latency and fixed contents.
    always @(posedge clk) begin
        for (int k = 0; k < 2*W; k++) begin
            rf_data[k*DW +: DW] <= mem[rf_addr[k*PR +: PR]];
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Distance form of the circular range test.
    function automatic bit tb_flushed(input bit [AL-1:0] p);
        bit [AL-1:0] dp, dt;
        dp = p - flush_head;
        dt = flush_tail - flush_head;
        return to_recovery && (flush_all || dp < dt);
    endfunction

    function automatic logic [2*DW-1:0] data_of(input op_t o);
        return {mem[o.s1], mem[o.s0]};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < W; l++) begin
            ma[l] = '{default: 0};
            mb[l] = '{default: 0};
        end
    endtask

    task automatic idle();
        in_valid = '0; clear = 1'b0; to_recovery = 1'b0; flush_all = 1'b0;
        flush_head = '0; flush_tail = '0; in_replay = 1'b0;
    endtask

    task automatic drive_op(input int l, input bit [AL-1:0] al, input bit [PR-1:0] s0,
                            input bit [PR-1:0] s1);
        in_valid[l]                = 1'b1;
        in_al_ptr[l*AL +: AL]      = al;
        in_iq_ptr[l*IQ +: IQ]      = IQ'($urandom);
        in_src[(2*l)*PR +: PR]     = s0;
        in_src[(2*l+1)*PR +: PR]   = s1;
        in_payload[l*PL +: PL]     = {$urandom, $urandom};
    endtask

    // Compare outputs against the model, then advance both by one clock.
    task automatic cycle();
        op_t na[W], nb[W];
        bit  ev;
        #1;
        for (int l = 0; l < W; l++) begin
            check_eq($sformatf("rf_addr[%0d]", l), rf_addr[(2*l)*PR +: 2*PR], {ma[l].s1, ma[l].s0});
            ev = mb[l].valid && !tb_flushed(mb[l].al);
            check_eq($sformatf("out_valid[%0d]", l), out_valid[l], ev);
            if (mb[l].valid) begin
                check_eq($sformatf("out_al[%0d]", l), out_al_ptr[l*AL +: AL], mb[l].al);
                check_eq($sformatf("out_iq[%0d]", l), out_iq_ptr[l*IQ +: IQ], mb[l].iq);
                check_eq($sformatf("out_payload[%0d]", l), out_payload[l*PL +: PL], mb[l].pl);
                check_eq($sformatf("out_replay[%0d]", l), out_replay[l], mb[l].replay);
            end
            if (ev) begin
                check_eq($sformatf("out_operand[%0d]", l), out_operand[l*2*DW +: 2*DW],
                         data_of(mb[l]));
                if (!stall) n_exp++;
            end
            if (out_valid[l] && !stall) n_got++;
            if (stall) begin
                na[l] = ma[l]; na[l].valid = ma[l].valid && !tb_flushed(ma[l].al);
                nb[l] = mb[l]; nb[l].valid = mb[l].valid && !tb_flushed(mb[l].al);
            end else begin
                nb[l] = ma[l]; nb[l].valid = ma[l].valid && !clear && !tb_flushed(ma[l].al);
                na[l].al     = in_al_ptr[l*AL +: AL];
                na[l].valid  = in_valid[l] && !clear && !tb_flushed(na[l].al);
                na[l].replay = in_replay;
                na[l].iq     = in_iq_ptr[l*IQ +: IQ];
                na[l].s0     = in_src[(2*l)*PR +: PR];
                na[l].s1     = in_src[(2*l+1)*PR +: PR];
                na[l].pl     = in_payload[l*PL +: PL];
            end
        end
        @(posedge clk);
        ma = na;
        mb = nb;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[3] = 32'h11;
        mem[9] = 32'h22;
        in_iq_ptr = '0; in_al_ptr = '0; in_src = '0; in_payload = '0;
        idle();
        stall = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_operand", out_operand, rf_data);
        @(negedge clk);
        rst = 1'b1;

        // Single op with known operands, two-cycle latency.
        drive_op(0, 6'd5, 7'd3, 7'd9);
        cycle();
        idle();
        cycle();
        #1;
        check_eq("single_valid", out_valid[0], 1'b1);
        check_eq("single_operand", out_operand[2*DW-1:0], 64'h00000022_00000011);
        cycle();

        // X then Y, stall three cycles once X is in B.
        drive_op(0, 6'd10, 7'd3, 7'd9);
        cycle();
        drive_op(0, 6'd11, 7'd20, 7'd21);
        cycle();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_operand", out_operand[2*DW-1:0], 64'h00000022_00000011);
            check_eq("stall_al", out_al_ptr[AL-1:0], 6'd10);
            cycle();
        end
        stall = 1'b0;
        cycle();
        #1;
        check_eq("after_stall_valid", out_valid[0], 1'b1);
        check_eq("after_stall_al", out_al_ptr[AL-1:0], 6'd11);
        cycle();
        cycle();

        // Wrapped flush range [62, 2).
        drive_op(0, 6'd63, 7'd1, 7'd2);
        drive_op(1, 6'd1, 7'd4, 7'd5);
        cycle();
        idle();
        drive_op(0, 6'd2, 7'd6, 7'd7);
        to_recovery = 1'b1; flush_head = 6'd62; flush_tail = 6'd2;
        cycle();
        idle();
        #1;
        check_eq("wrap_dropped", out_valid, 2'b00);
        cycle();
        #1;
        check_eq("wrap_pass_valid", out_valid, 2'b01);
        check_eq("wrap_pass_al", out_al_ptr[AL-1:0], 6'd2);
        cycle();

        // flush_all while stalled with ops in A and B.
        drive_op(0, 6'd20, 7'd8, 7'd9);
        drive_op(1, 6'd21, 7'd10, 7'd11);
        cycle();
        idle();
        drive_op(0, 6'd22, 7'd12, 7'd13);
        cycle();
        idle();
        stall = 1'b1; to_recovery = 1'b1; flush_all = 1'b1;
        #1;
        check_eq("flush_all_same_cycle", out_valid, 2'b00);
        cycle();
        idle();
        cycle();
        stall = 1'b0;
        cycle();
        #1;
        check_eq("flush_all_a_dropped", out_valid, 2'b00);
        cycle();

        // Clear pulse kills the op presented with it only.
        drive_op(0, 6'd30, 7'd14, 7'd15);
        clear = 1'b1;
        cycle();
        idle();
        drive_op(0, 6'd31, 7'd16, 7'd17);
        cycle();
        idle();
        #1;
        check_eq("clear_dropped", out_valid[0], 1'b0);
        cycle();
        #1;
        check_eq("clear_next_valid", out_valid[0], 1'b1);
        check_eq("clear_next_al", out_al_ptr[AL-1:0], 6'd31);
        cycle();

        // Asynchronous reset in the middle of a stall.
        drive_op(0, 6'd40, 7'd18, 7'd19);
        drive_op(1, 6'd41, 7'd22, 7'd23);
        cycle();
        cycle();
        idle();
        stall = 1'b1;
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 2'b00);
        check_eq("rst_rf_addr", rf_addr, 0);
        check_eq("rst_hold0", dut.g_lane[0].u_hold.hold_q, 0);
        check_eq("rst_hold1", dut.g_lane[1].u_hold.hold_q, 0);
        check_eq("rst_operand", out_operand, rf_data);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int l = 0; l < W; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    drive_op(l, AL'($urandom), PR'($urandom), PR'($urandom));
                end
            end
            in_replay   = 1'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            clear       = ($urandom_range(0, 15) == 0);
            to_recovery = ($urandom_range(0, 7) == 0);
            flush_all   = ($urandom_range(0, 3) == 0);
            flush_head  = AL'($urandom);
            flush_tail  = AL'($urandom);
            cycle();
        end
        idle();
        stall = 1'b0;
        repeat (3) cycle();

        check_eq("op_count", n_got, n_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
